// File: rtl/seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan_decoder
//  Description : Receive side of a multiplexed 7-segment display bus.
//                Samples the scanned seg/an lines, waits for each dwell to
//                settle, decodes the segment pattern to BCD per position and
//                publishes complete four-digit frames. Flags malformed scans,
//                undecodable patterns and a stalled display.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_i,
  input  logic [3:0]  an_i,
  output logic [15:0] digits_o,
  output logic [3:0]  blank_o,
  output logic        frame_valid_o,
  output logic        frame_stb_o,
  output logic        invalid_pattern_o,
  output logic        scan_error_o,
  output logic        stall_o
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] C_SETTLE_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] C_SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] C_TIMEOUT     = TW'(TIMEOUT_CYCLES);

  logic [10:0]   in_q;
  logic [SW-1:0] stable_q, stable_d;
  logic [15:0]   shadow_q;
  logic [3:0]    shadow_blank_q;
  logic [3:0]    mask_q, mask_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [15:0]   digits_q;
  logic [3:0]    blank_q;
  logic          frame_valid_q, frame_stb_q, invalid_q, scan_err_q;

  logic [6:0] seg_r;
  logic [3:0] an_r;
  logic       changed, capture_evt, cap, an_blank, an_multi;
  logic [3:0] pos_oh;
  logic [3:0] dec_val;
  logic       dec_blank, dec_invalid;
  logic       frame_done;

  assign seg_r       = in_q[10:4];
  assign an_r        = in_q[3:0];
  assign changed     = ({seg_i, an_i} != in_q);
  // The dwell has been seen SETTLE_CYCLES times in a row on this edge; the
  // saturating counter guarantees this fires only once per dwell.
  assign capture_evt = (stable_q == C_SETTLE_LAST);
  assign an_blank    = (an_r == 4'b1111);
  assign an_multi    = (pos_oh == 4'b0000) && !an_blank;
  assign cap         = capture_evt && (pos_oh != 4'b0000);
  assign frame_done  = (mask_q == 4'b1111);

  // Position select: only a single low anode identifies a digit.
  always_comb begin
    pos_oh = 4'b0000;
    case (an_r)
      4'b1110: pos_oh = 4'b0001;
      4'b1101: pos_oh = 4'b0010;
      4'b1011: pos_oh = 4'b0100;
      4'b0111: pos_oh = 4'b1000;
      default: pos_oh = 4'b0000;
    endcase
  end

  // Segment decode (active-low, bit order g..a).
  always_comb begin
    dec_val     = 4'hE;
    dec_blank   = 1'b0;
    dec_invalid = 1'b0;
    case (seg_r)
      7'b1000000: dec_val = 4'd0;
      7'b1111001: dec_val = 4'd1;
      7'b0100100: dec_val = 4'd2;
      7'b0110000: dec_val = 4'd3;
      7'b0011001: dec_val = 4'd4;
      7'b0010010: dec_val = 4'd5;
      7'b0000010: dec_val = 4'd6;
      7'b1111000: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0010000: dec_val = 4'd9;
      7'b1111111: begin
        dec_val   = 4'hF;
        dec_blank = 1'b1;
      end
      default: dec_invalid = 1'b1;
    endcase
  end

  // Next-state for the settle counter, capture mask and stall counter.
  always_comb begin
    stable_d = stable_q;
    if (changed) begin
      stable_d = '0;
    end else if (stable_q != C_SETTLE_MAX) begin
      stable_d = stable_q + 1'b1;
    end

    // A capture on the transfer edge seeds the next frame's mask.
    mask_d = frame_done ? 4'b0000 : mask_q;
    if (cap) begin
      mask_d = mask_d | pos_oh;
    end

    idle_d = idle_q;
    if (cap) begin
      idle_d = '0;
    end else if (idle_q != C_TIMEOUT) begin
      idle_d = idle_q + 1'b1;
    end
  end

  // Input sampling, settle tracking, shadow capture and frame publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q           <= '0;
      stable_q       <= '0;
      shadow_q       <= '0;
      shadow_blank_q <= '0;
      mask_q         <= '0;
      idle_q         <= '0;
      digits_q       <= '0;
      blank_q        <= '0;
      frame_valid_q  <= 1'b0;
      frame_stb_q    <= 1'b0;
      invalid_q      <= 1'b0;
      scan_err_q     <= 1'b0;
    end else begin
      in_q        <= {seg_i, an_i};
      stable_q    <= stable_d;
      mask_q      <= mask_d;
      idle_q      <= idle_d;
      frame_stb_q <= frame_done;
      invalid_q   <= cap && dec_invalid;
      scan_err_q  <= capture_evt && an_multi;
      for (int i = 0; i < 4; i++) begin
        if (cap && pos_oh[i]) begin
          shadow_q[4*i +: 4] <= dec_val;
          shadow_blank_q[i]  <= dec_blank;
        end
      end
      if (frame_done) begin
        digits_q      <= shadow_q;
        blank_q       <= shadow_blank_q;
        frame_valid_q <= 1'b1;
      end
    end
  end

  assign digits_o          = digits_q;
  assign blank_o           = blank_q;
  assign frame_valid_o     = frame_valid_q;
  assign frame_stb_o       = frame_stb_q;
  assign invalid_pattern_o = invalid_q;
  assign scan_error_o      = scan_err_q;
  assign stall_o           = (idle_q == C_TIMEOUT);

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scan_decoder
//  Description : Directed self-checking bench for seven_seg_scan_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_decoder;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 100;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SX = 7'b1010101;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        frame_valid, frame_stb, invalid_pattern, scan_error, stall;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  int serr_cnt = 0;
  int inv_cnt = 0;

  seven_seg_scan_decoder #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .seg_i            (seg),
    .an_i             (an),
    .digits_o         (digits),
    .blank_o          (blank),
    .frame_valid_o    (frame_valid),
    .frame_stb_o      (frame_stb),
    .invalid_pattern_o(invalid_pattern),
    .scan_error_o     (scan_error),
    .stall_o          (stall)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (frame_stb === 1'b1) stb_cnt++;
    if (scan_error === 1'b1) serr_cnt++;
    if (invalid_pattern === 1'b1) inv_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] s, input logic [3:0] a, input int n);
    seg = s;
    an  = a;
    cyc(n);
  endtask

  task automatic test_reset;
    checks++;
    if (digits !== 16'h0000) begin errors++; $display("FAIL reset_digits got=%h exp=0000", digits); end
    checks++;
    if (blank !== 4'h0) begin errors++; $display("FAIL reset_blank got=%b exp=0000", blank); end
    checks++;
    if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid got=%b exp=0", frame_valid); end
    checks++;
    if ({frame_stb, invalid_pattern, scan_error} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got=%b exp=000", {frame_stb, invalid_pattern, scan_error});
    end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
  endtask

  task automatic test_basic_frame;
    int b;
    b = stb_cnt;
    drive(S1, 4'b0111, 10);
    drive(S2, 4'b1011, 10);
    drive(S3, 4'b1101, 10);
    checks++;
    if (frame_valid !== 1'b0 || digits !== 16'h0000) begin
      errors++; $display("FAIL partial_frame valid=%b digits=%h exp valid=0 digits=0000", frame_valid, digits);
    end
    drive(S4, 4'b1110, 10);
    drive(SB, 4'b1111, 5);
    checks++;
    if (stb_cnt - b !== 1) begin errors++; $display("FAIL basic_stb_count got=%0d exp=1", stb_cnt - b); end
    checks++;
    if (digits !== 16'h1234) begin errors++; $display("FAIL basic_digits got=%h exp=1234", digits); end
    checks++;
    if (blank !== 4'b0000) begin errors++; $display("FAIL basic_blank got=%b exp=0000", blank); end
    checks++;
    if (frame_valid !== 1'b1) begin errors++; $display("FAIL basic_frame_valid got=%b exp=1", frame_valid); end
  endtask

  task automatic test_short_dwell;
    int b;
    b = stb_cnt;
    drive(S5, 4'b1110, 3);
    drive(SB, 4'b1111, 6);
    drive(S7, 4'b0111, 10);
    drive(S8, 4'b1011, 10);
    drive(S9, 4'b1101, 10);
    drive(SB, 4'b1111, 6);
    checks++;
    if (stb_cnt - b !== 0) begin errors++; $display("FAIL short_dwell_no_stb got=%0d exp=0", stb_cnt - b); end
    checks++;
    if (digits !== 16'h1234) begin errors++; $display("FAIL short_dwell_hold got=%h exp=1234", digits); end
    drive(S0, 4'b1110, SETTLE);
    drive(SB, 4'b1111, 6);
    checks++;
    if (stb_cnt - b !== 1) begin errors++; $display("FAIL min_dwell_stb got=%0d exp=1", stb_cnt - b); end
    checks++;
    if (digits !== 16'h7890) begin errors++; $display("FAIL min_dwell_digits got=%h exp=7890", digits); end
  endtask

  task automatic test_scan_error;
    int bs, be, bi;
    bs = stb_cnt; be = serr_cnt; bi = inv_cnt;
    drive(S1, 4'b1100, 10);
    drive(SB, 4'b1111, 5);
    checks++;
    if (serr_cnt - be !== 1) begin errors++; $display("FAIL scan_error_count got=%0d exp=1", serr_cnt - be); end
    checks++;
    if (stb_cnt - bs !== 0 || inv_cnt - bi !== 0) begin
      errors++; $display("FAIL scan_error_side stb=%0d inv=%0d exp 0 0", stb_cnt - bs, inv_cnt - bi);
    end
  endtask

  task automatic test_invalid_blank;
    int bs, bi;
    bs = stb_cnt; bi = inv_cnt;
    drive(S3, 4'b0111, 10);
    drive(SB, 4'b1011, 10);
    drive(SX, 4'b1101, 10);
    drive(S8, 4'b1110, 10);
    drive(SB, 4'b1111, 5);
    checks++;
    if (stb_cnt - bs !== 1) begin errors++; $display("FAIL invalid_stb got=%0d exp=1", stb_cnt - bs); end
    checks++;
    if (digits !== 16'h3FE8) begin errors++; $display("FAIL invalid_digits got=%h exp=3fe8", digits); end
    checks++;
    if (blank !== 4'b0100) begin errors++; $display("FAIL invalid_blank got=%b exp=0100", blank); end
    checks++;
    if (inv_cnt - bi !== 1) begin errors++; $display("FAIL invalid_count got=%0d exp=1", inv_cnt - bi); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL stall_early got=%b exp=0", stall); end
  endtask

  task automatic test_stall;
    drive(SB, 4'b1111, TIMEOUT + 10);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL stall_set got=%b exp=1", stall); end
    drive(S1, 4'b1100, 10);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL stall_scan_err got=%b exp=1", stall); end
    drive(SB, 4'b1111, 3);
    drive(S1, 4'b1110, SETTLE);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL stall_pre_capture got=%b exp=1", stall); end
    cyc(1);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL stall_clear got=%b exp=0", stall); end
    drive(SB, 4'b1111, 5);
  endtask

  task automatic test_reset_mid_frame;
    int b;
    drive(S2, 4'b0111, 10);
    drive(S2, 4'b1011, 10);
    rst = 1'b1;
    seg = SB;
    an  = 4'b1111;
    cyc(2);
    checks++;
    if (digits !== 16'h0000 || blank !== 4'h0 || frame_valid !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs digits=%h blank=%b valid=%b stall=%b exp all 0",
                         digits, blank, frame_valid, stall);
    end
    rst = 1'b0;
    cyc(3);
    b = stb_cnt;
    drive(S6, 4'b1101, 10);
    drive(S7, 4'b1110, 10);
    drive(SB, 4'b1111, 5);
    checks++;
    if (stb_cnt - b !== 0 || frame_valid !== 1'b0 || digits !== 16'h0000) begin
      errors++; $display("FAIL midreset_partial stb=%0d valid=%b digits=%h exp 0 0 0000",
                         stb_cnt - b, frame_valid, digits);
    end
    drive(S4, 4'b0111, 10);
    drive(S5, 4'b1011, 10);
    drive(SB, 4'b1111, 5);
    checks++;
    if (stb_cnt - b !== 1) begin errors++; $display("FAIL midreset_stb got=%0d exp=1", stb_cnt - b); end
    checks++;
    if (digits !== 16'h4567 || frame_valid !== 1'b1) begin
      errors++; $display("FAIL midreset_frame digits=%h valid=%b exp 4567 1", digits, frame_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    seg = SB;
    an  = 4'b1111;
    cyc(3);
    test_reset();
    rst = 1'b0;
    cyc(5);
    test_basic_frame();
    test_short_dwell();
    test_scan_error();
    test_invalid_blank();
    test_stall();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
